// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - RAW hazard flags, load-use stall, redirect flush and event counters
module hazard_detect_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rR1,
    input  logic [4:0]       id_rR2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic             id_we,
    input  logic [4:0]       id_wR,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             RAW_A_rR1,
    output logic             RAW_A_rR2,
    output logic             RAW_B_rR1,
    output logic             RAW_B_rR2,
    output logic             RAW_C_rR1,
    output logic             RAW_C_rR2,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // EX slot (the only slot that needs the load marker)
    logic             ex_v_q,  ex_v_d;
    logic             ex_we_q, ex_we_d;
    logic [4:0]       ex_wr_q, ex_wr_d;
    logic             ex_ld_q, ex_ld_d;
    // MEM slot
    logic             mem_v_q,  mem_v_d;
    logic             mem_we_q, mem_we_d;
    logic [4:0]       mem_wr_q, mem_wr_d;
    // WB slot
    logic             wb_v_q,  wb_v_d;
    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_wr_q, wb_wr_d;
    // event counters
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic load_use;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Source/slot matching: a slot only counts if it is live, writes, and targets a non-x0 register
    always_comb begin
        ex_m1  = ex_v_q  & ex_we_q  & (ex_wr_q  != 5'd0) & (ex_wr_q  == id_rR1) & id_re1 & id_valid;
        ex_m2  = ex_v_q  & ex_we_q  & (ex_wr_q  != 5'd0) & (ex_wr_q  == id_rR2) & id_re2 & id_valid;
        mem_m1 = mem_v_q & mem_we_q & (mem_wr_q != 5'd0) & (mem_wr_q == id_rR1) & id_re1 & id_valid;
        mem_m2 = mem_v_q & mem_we_q & (mem_wr_q != 5'd0) & (mem_wr_q == id_rR2) & id_re2 & id_valid;
        wb_m1  = wb_v_q  & wb_we_q  & (wb_wr_q  != 5'd0) & (wb_wr_q  == id_rR1) & id_re1 & id_valid;
        wb_m2  = wb_v_q  & wb_we_q  & (wb_wr_q  != 5'd0) & (wb_wr_q  == id_rR2) & id_re2 & id_valid;
        load_use = (ex_m1 | ex_m2) & ex_ld_q;
    end

    // Hazard outputs; redirect wins over load-use, and everything is held low during reset
    always_comb begin
        RAW_A_rR1   = ex_m1 & ~ex_ld_q;
        RAW_A_rR2   = ex_m2 & ~ex_ld_q;
        RAW_B_rR1   = mem_m1;
        RAW_B_rR2   = mem_m2;
        RAW_C_rR1   = wb_m1;
        RAW_C_rR2   = wb_m2;
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
        if (!rst_n) begin
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    // Next slot contents and saturating counter updates
    always_comb begin
        mem_v_d  = ex_v_q;
        mem_we_d = ex_we_q;
        mem_wr_d = ex_wr_q;
        wb_v_d   = mem_v_q;
        wb_we_d  = mem_we_q;
        wb_wr_d  = mem_wr_q;
        ex_v_d   = id_valid;
        ex_we_d  = id_we;
        ex_wr_d  = id_wR;
        ex_ld_d  = id_is_load;
        if (flush_id_ex) begin
            ex_v_d  = 1'b0;
            ex_we_d = 1'b0;
            ex_wr_d = 5'd0;
            ex_ld_d = 1'b0;
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_use && !ex_redirect && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (ex_redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Slot and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q      <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_wr_q     <= 5'd0;
            ex_ld_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wr_q    <= 5'd0;
            wb_v_q      <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_wr_q     <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_we_q     <= ex_we_d;
            ex_wr_q     <= ex_wr_d;
            ex_ld_q     <= ex_ld_d;
            mem_v_q     <= mem_v_d;
            mem_we_q    <= mem_we_d;
            mem_wr_q    <= mem_wr_d;
            wb_v_q      <= wb_v_d;
            wb_we_q     <= wb_we_d;
            wb_wr_q     <= wb_wr_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb/tb_hazard_detect_unit.sv - randomized and directed check of hazard_detect_unit against a pipeline-history model
module tb_hazard_detect_unit;

    localparam int CW = 4;

    logic          clk, rst_n;
    logic          id_valid, id_re1, id_re2, id_we, id_is_load, ex_redirect;
    logic [4:0]    id_rR1, id_rR2, id_wR;
    logic          RAW_A_rR1, RAW_A_rR2, RAW_B_rR1, RAW_B_rR2, RAW_C_rR1, RAW_C_rR2;
    logic          stall_pc, stall_if_id, flush_if_id, flush_id_ex;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_detect_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rR1(id_rR1), .id_rR2(id_rR2),
        .id_re1(id_re1), .id_re2(id_re2), .id_we(id_we), .id_wR(id_wR), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .RAW_A_rR1(RAW_A_rR1), .RAW_A_rR2(RAW_A_rR2),
        .RAW_B_rR1(RAW_B_rR1), .RAW_B_rR2(RAW_B_rR2), .RAW_C_rR1(RAW_C_rR1), .RAW_C_rR2(RAW_C_rR2),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of the last three instructions that left ID (index 0 = EX, 1 = MEM, 2 = WB)
    typedef struct { bit v; bit we; bit [4:0] wr; bit ld; } instr_t;
    instr_t pipe[3];
    int     m_stall, m_flush;
    bit     m_kill;
    int     tests, fails;

    function automatic bit hit(int s, bit [4:0] r, bit re);
        return id_valid && re && pipe[s].v && pipe[s].we && pipe[s].wr != 5'd0 && pipe[s].wr == r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] outs();
        return {RAW_A_rR1, RAW_A_rR2, RAW_B_rR1, RAW_B_rR2, RAW_C_rR1, RAW_C_rR2,
                stall_pc, stall_if_id, flush_if_id, flush_id_ex};
    endfunction

    // Compare the DUT with what the model says the outputs must be this cycle
    task automatic model_check();
        bit lu, a1, a2;
        logic [9:0] e;
        lu = (hit(0, id_rR1, id_re1) || hit(0, id_rR2, id_re2)) && pipe[0].ld;
        a1 = hit(0, id_rR1, id_re1) && !pipe[0].ld;
        a2 = hit(0, id_rR2, id_re2) && !pipe[0].ld;
        e  = {a1, a2, hit(1, id_rR1, id_re1), hit(1, id_rR2, id_re2),
              hit(2, id_rR1, id_re1), hit(2, id_rR2, id_re2),
              lu && !ex_redirect, lu && !ex_redirect, ex_redirect, ex_redirect || lu};
        m_kill = ex_redirect || lu;
        chk("outputs", outs(), e);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        if (lu && !ex_redirect && m_stall < 15) m_stall++;
        if (ex_redirect && m_flush < 15) m_flush++;
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (m_kill) pipe[0] = '{0, 0, 5'd0, 0};
        else        pipe[0] = '{id_valid, id_we, id_wR, id_is_load};
        #1;
    endtask

    task automatic drive(bit v, bit [4:0] r1, bit re1, bit [4:0] r2, bit re2,
                         bit we, bit [4:0] wr, bit ld, bit redir);
        id_valid = v; id_rR1 = r1; id_re1 = re1; id_rR2 = r2; id_re2 = re2;
        id_we = we; id_wR = wr; id_is_load = ld; ex_redirect = redir;
    endtask

    task automatic step();
        at_neg();
        adv();
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 5'd0, 0};
        m_stall = 0;
        m_flush = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_clear();
        rst_n = 1'b0;
        drive(1, 5'd1, 1, 5'd2, 1, 1, 5'd1, 1, 1);
        @(negedge clk);
        chk("reset_outputs", outs(), 10'd0);
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_flush_cnt", flush_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain();

        // add x5 ; add x6,x5,x0 (held) -> forward from EX, then MEM, then WB
        drive(1, 0, 0, 0, 0, 1, 5'd5, 0, 0); step();
        drive(1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0);
        at_neg(); chk("t1_c2", outs(), 10'b10_00_00_0000); adv();
        at_neg(); chk("t1_c3", outs(), 10'b00_10_00_0000); adv();
        at_neg(); chk("t1_c4", outs(), 10'b00_00_10_0000); adv();
        drain();

        // lw x7 ; add x8,x7,x7 -> one stall cycle, then MEM forwarding on both sources
        drive(1, 0, 0, 0, 0, 1, 5'd7, 1, 0); step();
        drive(1, 5'd7, 1, 5'd7, 1, 1, 5'd8, 0, 0);
        at_neg(); chk("t2_stall", outs(), 10'b00_00_00_1101); adv();
        at_neg(); chk("t2_after", outs(), 10'b00_11_00_0000);
        chk("t2_stall_cnt", stall_cnt, 1); adv();
        drain();

        // write x0, write x3, reader with re1=0 on x3 and re2 on x0 -> nothing
        drive(1, 0, 0, 0, 0, 1, 5'd0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 1, 5'd3, 0, 0); step();
        drive(1, 5'd3, 0, 5'd0, 1, 0, 0, 0, 0);
        at_neg(); chk("t3_quiet", outs(), 10'd0); adv();
        drain();

        // lw x7 in EX, reader of x7, redirect same cycle -> flush wins
        drive(1, 0, 0, 0, 0, 1, 5'd7, 1, 0); step();
        drive(1, 5'd7, 1, 5'd0, 0, 0, 0, 0, 1);
        at_neg(); chk("t4_flush", outs(), 10'b00_00_00_0011); adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        at_neg(); chk("t4_stall_cnt", stall_cnt, 1); chk("t4_flush_cnt", flush_cnt, 1); adv();
        drain();

        // x9 written by three instructions in a row -> A, B and C together
        drive(1, 0, 0, 0, 0, 1, 5'd9, 0, 0); repeat (3) step();
        drive(1, 5'd9, 1, 5'd0, 0, 0, 0, 0, 0);
        at_neg(); chk("t5_abc", outs(), 10'b10_10_10_0000); adv();
        drain();

        // Randomized traffic on a small register window so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 5) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            step();
            if (n == 200) begin
                rst_n = 1'b0; #1;
                model_clear();
                chk("rand_reset_outputs", outs() & 10'b11_11_11_1100, 10'd0);
                rst_n = 1'b1;
            end
        end
        drain();

        // Saturate the stall counter with 16 load-use stalls
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 0, 0, 0, 1, 5'd7, 1, 0); step();
            drive(1, 5'd7, 1, 5'd0, 0, 0, 0, 0, 0); step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        at_neg(); chk("t6_saturated", stall_cnt, 4'hF); adv();

        // Reset pulse in the middle of a stall, with a redirect also asserted
        drive(1, 0, 0, 0, 0, 1, 5'd7, 1, 0); step();
        drive(1, 5'd7, 1, 5'd0, 0, 0, 0, 0, 0);
        at_neg(); chk("t6_prestall", outs(), 10'b00_00_00_1101);
        ex_redirect = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        chk("t6_reset_outs", outs(), 10'd0);
        chk("t6_reset_stall_cnt", stall_cnt, 0);
        chk("t6_reset_flush_cnt", flush_cnt, 0);
        ex_redirect = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        at_neg(); chk("t6_no_stale", outs(), 10'd0); adv();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
